// File: rtl/axi_stream_arb_pkg.sv
// axi_stream_arb_pkg: shared types and sizing helpers for the packet arbiter.
//   state_t   arbiter FSM state (IDLE waits/arbitrates, BUSY holds a locked grant)
//   clog2     ceiling log2 for parameter arithmetic
//   idx_w     width of a port index (never narrower than 1 bit)
package axi_stream_arb_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) if ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int idx_w(input int n);
    return n < 2 ? 1 : clog2(n);
  endfunction
endpackage

// File: rtl/axi_stream_rr_pick.sv
// axi_stream_rr_pick: combinational round-robin picker.
//   req   in  NUM_IN  request vector
//   last  in  IDX_W   most recently served index; search starts at last+1
//   pick  out IDX_W   first requester found scanning last+1, last+2, ... (wrapping)
//   any   out 1       at least one request present
module axi_stream_rr_pick
  import axi_stream_arb_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int IDX_W = idx_w(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic [IDX_W-1:0]  pick,
  output logic              any
);
  int base;
  logic [NUM_IN-1:0] rot;
  logic [IDX_W-1:0] off;
  // Doubling the request vector lets a plain right shift act as a rotate,
  // so bit 0 of rot is always the port right after last.
  always_comb begin
    base = int'(last) + 1;
    rot = NUM_IN'({req, req} >> base);
    off = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) if (rot[i]) off = IDX_W'(i);
    pick = IDX_W'((base + int'(off)) % NUM_IN);
  end
  assign any = |req;
endmodule

// File: rtl/axi_stream_packet_arbiter.sv
// axi_stream_packet_arbiter: packet-granular round-robin merge of NUM_IN AXI4-Stream slaves.
//   clk, resetn           clock, asynchronous active-low reset
//   s_tvalid/s_tready     per-port handshake
//   s_tdata/tkeep/tlast/tuser  packed per-port beat fields, port i in slice i
//   m_tvalid/m_tready     merged handshake
//   m_tdata/tkeep/tlast/tuser  merged beat fields
//   m_tid                 source port of the current beat
//   busy                  high while a grant is locked to one port
module axi_stream_packet_arbiter
  import axi_stream_arb_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int BYTE_WIDTH = 4,
  parameter int USER_WIDTH = 1,
  localparam int IDX_W = idx_w(NUM_IN),
  localparam int DW = 8 * BYTE_WIDTH
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_IN-1:0]            s_tvalid,
  output logic [NUM_IN-1:0]            s_tready,
  input  logic [NUM_IN*DW-1:0]         s_tdata,
  input  logic [NUM_IN*BYTE_WIDTH-1:0] s_tkeep,
  input  logic [NUM_IN-1:0]            s_tlast,
  input  logic [NUM_IN*USER_WIDTH-1:0] s_tuser,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [DW-1:0]                m_tdata,
  output logic [BYTE_WIDTH-1:0]        m_tkeep,
  output logic                         m_tlast,
  output logic [USER_WIDTH-1:0]        m_tuser,
  output logic [IDX_W-1:0]             m_tid,
  output logic                         busy
);
  state_t state, state_nx;
  logic [IDX_W-1:0] grant, last_grant, pick;
  logic any, fire;
  axi_stream_rr_pick #(.NUM_IN(NUM_IN), .IDX_W(IDX_W)) u_pick (
    .req(s_tvalid), .last(last_grant), .pick(pick), .any(any)
  );
  assign fire = busy && m_tvalid && m_tready && m_tlast;
  // last_grant resets to the top index so port 0 is scanned first.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= IDX_W'(NUM_IN - 1);
    end else begin
      state <= state_nx;
      if (state == IDLE && any) grant <= pick;
      if (fire) last_grant <= grant;
    end
  end
  always_comb state_nx = state == IDLE ? (any ? BUSY : IDLE) : (fire ? IDLE : BUSY);
  // No buffering: the granted port is wired straight through in both directions.
  always_comb begin
    busy = state == BUSY;
    m_tid = grant;
    m_tvalid = busy && s_tvalid[grant];
    m_tdata = s_tdata[int'(grant)*DW +: DW];
    m_tkeep = s_tkeep[int'(grant)*BYTE_WIDTH +: BYTE_WIDTH];
    m_tlast = s_tlast[grant];
    m_tuser = s_tuser[int'(grant)*USER_WIDTH +: USER_WIDTH];
    s_tready = '0;
    s_tready[grant] = busy && m_tready;
  end
endmodule

// File: tb/tb_axi_stream_packet_arbiter.sv
// tb_axi_stream_packet_arbiter: vector table, directed corner cases and a randomized scoreboard run.
module tb_axi_stream_packet_arbiter;
  localparam int N = 4, BW = 4, UW = 1, DW = 32;
  logic clk = 0, resetn = 1;
  logic [N-1:0] s_tvalid, s_tready, s_tlast;
  logic [N*DW-1:0] s_tdata;
  logic [N*BW-1:0] s_tkeep;
  logic [N*UW-1:0] s_tuser;
  logic m_tvalid, m_tready, m_tlast, busy;
  logic [DW-1:0] m_tdata;
  logic [BW-1:0] m_tkeep;
  logic [UW-1:0] m_tuser;
  logic [1:0] m_tid;
  axi_stream_packet_arbiter #(.NUM_IN(N), .BYTE_WIDTH(BW), .USER_WIDTH(UW)) dut (
    .clk(clk), .resetn(resetn), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .m_tid(m_tid), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [3:0] v;
    logic [3:0] tl;
    logic rdy;
    logic mv;
    logic [3:0] sr;
    logic bz;
    logic [1:0] tid;
    logic etl;
  } vec_t;
  vec_t tbl[21];
  int n_chk = 0, n_fail = 0;
  logic [N-1:0] v, gap;
  logic [DW-1:0] dat[N];
  logic [BW-1:0] kp[N];
  logic lst[N], usr[N];
  int bn[N], len[N];
  int plen = 0;
  bit rmode = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic new_beat(input int i);
    dat[i] = {8'(i), 8'(bn[i]), 16'($urandom)};
    kp[i] = 4'($urandom);
    lst[i] = (bn[i] == len[i] - 1);
    usr[i] = 1'($urandom);
  endtask
  task automatic src_init();
    for (int i = 0; i < N; i++) begin
      bn[i] = 0;
      len[i] = plen > 0 ? plen : int'($urandom_range(1, 4));
      new_beat(i);
    end
  endtask
  task automatic drive();
    s_tvalid = v & ~gap;
    for (int i = 0; i < N; i++) begin
      s_tdata[i*DW +: DW] = dat[i];
      s_tkeep[i*BW +: BW] = kp[i];
      s_tlast[i] = lst[i];
      s_tuser[i] = usr[i];
    end
  endtask
  task automatic run_cycle(input logic rdy);
    m_tready = rdy;
    drive();
    #1;
  endtask
  task automatic finish_cycle();
    logic [N-1:0] hs;
    hs = s_tready & s_tvalid;
    tick();
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        if (lst[i]) begin
          bn[i] = 0;
          len[i] = plen > 0 ? plen : int'($urandom_range(1, 4));
        end else bn[i]++;
        new_beat(i);
        if (rmode) v[i] = 1'($urandom_range(0, 1));
      end else if (rmode && !v[i]) v[i] = 1'($urandom_range(0, 1));
    end
  endtask
  task automatic do_reset();
    resetn = 0;
    v = '0;
    gap = '0;
    rmode = 0;
    m_tready = 1;
    drive();
    #1;
    chk("reset m_tvalid", m_tvalid, 0);
    chk("reset s_tready", s_tready, 0);
    chk("reset busy", busy, 0);
    repeat (2) tick();
    resetn = 1;
    src_init();
  endtask
  initial begin
    tbl[0]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[3]  = '{4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[4]  = '{4'b0100, 4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
    tbl[5]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[6]  = '{4'b0001, 4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[7]  = '{4'b0001, 4'b0001, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    tbl[8]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[9]  = '{4'b1010, 4'b1010, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[10] = '{4'b1010, 4'b1010, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    tbl[11] = '{4'b1000, 4'b1000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[12] = '{4'b1001, 4'b1001, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
    tbl[13] = '{4'b1001, 4'b1001, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[14] = '{4'b1001, 4'b1001, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1};
    tbl[15] = '{4'b1001, 4'b1001, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    tbl[16] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[17] = '{4'b0100, 4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[18] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[19] = '{4'b0100, 4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
    tbl[20] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
    v = '0;
    gap = '0;
    m_tready = 1;
    src_init();
    drive();
    #1;
    do_reset();
    for (int r = 0; r < 21; r++) begin
      v = tbl[r].v;
      for (int i = 0; i < N; i++) begin
        lst[i] = tbl[r].tl[i];
        dat[i] = 32'hD0D0_0000 | 32'(i);
      end
      run_cycle(tbl[r].rdy);
      chk($sformatf("row%0d m_tvalid", r), m_tvalid, tbl[r].mv);
      chk($sformatf("row%0d s_tready", r), s_tready, tbl[r].sr);
      chk($sformatf("row%0d busy", r), busy, tbl[r].bz);
      if (tbl[r].bz) chk($sformatf("row%0d m_tid", r), m_tid, tbl[r].tid);
      if (tbl[r].mv) begin
        chk($sformatf("row%0d m_tdata", r), m_tdata, 32'hD0D0_0000 | 32'(tbl[r].tid));
        chk($sformatf("row%0d m_tlast", r), m_tlast, tbl[r].etl);
      end
      tick();
    end
    begin : t2
      int order[$];
      bit inpk, bub;
      int cur;
      inpk = 0;
      bub = 0;
      cur = 0;
      plen = 2;
      do_reset();
      v = '1;
      for (int c = 0; c < 40 && order.size() < 6; c++) begin
        run_cycle(1);
        if (bub) begin
          chk("t2 bubble busy", busy, 0);
          chk("t2 bubble m_tvalid", m_tvalid, 0);
          bub = 0;
        end
        if (m_tvalid && m_tready) begin
          if (!inpk) begin
            order.push_back(int'(m_tid));
            cur = int'(m_tid);
            inpk = 1;
          end else chk("t2 no interleave", m_tid, cur);
          chk("t2 data source", m_tdata[31:24], m_tid);
          if (m_tlast) begin
            inpk = 0;
            bub = 1;
          end
        end
        finish_cycle();
      end
      chk("t2 packet count", order.size() >= 5, 1);
      for (int k = 0; k < 5 && k < order.size(); k++) chk($sformatf("t2 order%0d", k), order[k], k % 4);
    end
    begin : t3
      logic [DW-1:0] d0;
      plen = 4;
      do_reset();
      v = 4'b0010;
      run_cycle(1);
      chk("t3 idle busy", busy, 0);
      finish_cycle();
      v = 4'b1111;
      run_cycle(1);
      chk("t3 b1 s_tready", s_tready, 4'b0010);
      chk("t3 b1 m_tid", m_tid, 1);
      finish_cycle();
      run_cycle(0);
      d0 = dat[1];
      chk("t3 stall1 m_tvalid", m_tvalid, 1);
      chk("t3 stall1 s_tready", s_tready, 4'b0000);
      chk("t3 stall1 m_tdata", m_tdata, d0);
      finish_cycle();
      run_cycle(0);
      chk("t3 stall2 s_tready", s_tready, 4'b0000);
      chk("t3 stall2 m_tdata", m_tdata, d0);
      finish_cycle();
      run_cycle(1);
      chk("t3 resume s_tready", s_tready, 4'b0010);
      chk("t3 resume m_tdata", m_tdata, d0);
      finish_cycle();
    end
    plen = 2;
    do_reset();
    v = 4'b1000;
    run_cycle(1);
    finish_cycle();
    v = 4'b1001;
    run_cycle(1);
    chk("t4 b1 m_tid", m_tid, 3);
    chk("t4 b1 s_tready", s_tready, 4'b1000);
    finish_cycle();
    gap = 4'b1000;
    for (int k = 0; k < 2; k++) begin
      run_cycle(1);
      chk($sformatf("t4 gap%0d busy", k), busy, 1);
      chk($sformatf("t4 gap%0d m_tvalid", k), m_tvalid, 0);
      chk($sformatf("t4 gap%0d m_tid", k), m_tid, 3);
      chk($sformatf("t4 gap%0d s_tready", k), s_tready, 4'b1000);
      finish_cycle();
    end
    gap = '0;
    run_cycle(1);
    chk("t4 b2 m_tvalid", m_tvalid, 1);
    chk("t4 b2 m_tlast", m_tlast, 1);
    chk("t4 b2 m_tid", m_tid, 3);
    finish_cycle();
    run_cycle(1);
    chk("t4 bubble busy", busy, 0);
    finish_cycle();
    run_cycle(1);
    chk("t4 next m_tid", m_tid, 0);
    chk("t4 next s_tready", s_tready, 4'b0001);
    finish_cycle();
    plen = 4;
    do_reset();
    v = 4'b0010;
    run_cycle(1);
    finish_cycle();
    run_cycle(1);
    finish_cycle();
    run_cycle(1);
    chk("t5 beat2 m_tvalid", m_tvalid, 1);
    resetn = 0;
    #1;
    chk("t5 async m_tvalid", m_tvalid, 0);
    chk("t5 async s_tready", s_tready, 0);
    chk("t5 async busy", busy, 0);
    tick();
    resetn = 1;
    src_init();
    v = 4'b1010;
    run_cycle(1);
    chk("t5 idle busy", busy, 0);
    finish_cycle();
    run_cycle(1);
    chk("t5 grant m_tid", m_tid, 1);
    chk("t5 grant s_tready", s_tready, 4'b0010);
    finish_cycle();
    plen = 1;
    do_reset();
    v = 4'b0001;
    dat[0] = 32'hCAFE_0123;
    kp[0] = 4'b0011;
    usr[0] = 1;
    lst[0] = 1;
    run_cycle(1);
    chk("t6 idle m_tvalid", m_tvalid, 0);
    finish_cycle();
    run_cycle(1);
    chk("t6 m_tvalid", m_tvalid, 1);
    chk("t6 m_tdata", m_tdata, 32'hCAFE_0123);
    chk("t6 m_tkeep", m_tkeep, 4'b0011);
    chk("t6 m_tuser", m_tuser, 1);
    chk("t6 m_tlast", m_tlast, 1);
    chk("t6 m_tid", m_tid, 0);
    finish_cycle();
    v = '0;
    run_cycle(1);
    chk("t6 back idle busy", busy, 0);
    finish_cycle();
    begin : rnd
      bit mb;
      int mo, ml;
      logic rdy;
      logic [N-1:0] esr, sv;
      plen = 0;
      do_reset();
      rmode = 1;
      mb = 0;
      mo = 0;
      ml = N - 1;
      for (int c = 0; c < 3000; c++) begin
        rdy = ($urandom_range(0, 3) != 0);
        run_cycle(rdy);
        sv = v & ~gap;
        esr = (mb && rdy) ? N'(1 << mo) : '0;
        chk("rnd busy", busy, mb);
        chk("rnd m_tvalid", m_tvalid, mb && sv[mo]);
        chk("rnd s_tready", s_tready, esr);
        if (mb && sv[mo]) begin
          chk("rnd m_tid", m_tid, mo);
          chk("rnd m_tdata", m_tdata, dat[mo]);
          chk("rnd m_tkeep", m_tkeep, kp[mo]);
          chk("rnd m_tlast", m_tlast, lst[mo]);
          chk("rnd m_tuser", m_tuser, usr[mo]);
        end
        if (!mb) begin
          for (int k = 1; k <= N; k++) if (sv[(ml + k) % N]) begin
            mo = (ml + k) % N;
            mb = 1;
            break;
          end
        end else if (sv[mo] && rdy && lst[mo]) begin
          ml = mo;
          mb = 0;
        end
        finish_cycle();
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_stream_packet_arbiter.md
Name: axi_stream_packet_arbiter

Overview:
- Packet-granular round-robin arbiter. Merges NUM_IN AXI4-Stream slave ports onto one AXI4-Stream master port.
- Locks the grant from the first beat of a packet until its TLAST beat is accepted, so packets never interleave.
- Sits in front of shared stream sinks such as a DMA write channel or a serializer.
- Each upstream is protocol-checked by axi_stream_slave_monitor; the output is checked by the same monitor in master-facing mode.

Parameters:
- NUM_IN, 4, number of slave stream ports (2..16).
- BYTE_WIDTH, 4, TDATA bytes per beat (TDATA width = 8*BYTE_WIDTH).
- USER_WIDTH, 1, TUSER width per port (>=1).
- IDX_W (localparam), clog2(NUM_IN), width of the grant index and of m_tid.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- s_tvalid  in  NUM_IN  per-port TVALID.
- s_tready  out  NUM_IN  per-port TREADY.
- s_tdata  in  NUM_IN*8*BYTE_WIDTH  packed TDATA; port i occupies slice i.
- s_tkeep  in  NUM_IN*BYTE_WIDTH  packed TKEEP.
- s_tlast  in  NUM_IN  per-port TLAST.
- s_tuser  in  NUM_IN*USER_WIDTH  packed TUSER.
- m_tvalid  out  1  merged TVALID.
- m_tready  in  1  merged TREADY.
- m_tdata  out  8*BYTE_WIDTH  merged TDATA.
- m_tkeep  out  BYTE_WIDTH  merged TKEEP.
- m_tlast  out  1  merged TLAST.
- m_tuser  out  USER_WIDTH  merged TUSER.
- m_tid  out  IDX_W  index of the source port of the current beat.
- busy  out  1  high while a grant is locked.

Behaviour:
Reset (resetn low, asynchronous):
- state=IDLE, grant=0, last_grant=NUM_IN-1.
- All s_tready, m_tvalid, busy are 0 immediately.
- Reset mid-packet truncates the packet. No recovery beat is issued.
- After reset release, port 0 has the highest priority.

States and transitions:
- IDLE:
  - m_tvalid=0, all s_tready=0, busy=0.
  - If any s_tvalid is set, pick the first requester scanning last_grant+1, last_grant+2, ... with modulo-NUM_IN wrap.
  - Register the pick into grant and go to BUSY. Arbitration costs exactly one cycle.
  - With no requests, stay in IDLE.
- BUSY:
  - Combinational mux: m_tvalid=s_tvalid[grant], m_tdata/tkeep/tlast/tuser = slice[grant], m_tid=grant.
  - s_tready[grant]=m_tready; every other s_tready=0. busy=1.
  - On m_tvalid && m_tready && m_tlast: last_grant<=grant, go to IDLE.
  - Otherwise hold grant, even if s_tvalid[grant] drops between beats.
- Consequence: every packet is followed by at least one IDLE bubble cycle. Throughput within a packet is one beat per cycle.

Fairness:
- With all NUM_IN ports continuously requesting, packets are granted in order 0,1,...,NUM_IN-1,0,...
- A port waits at most NUM_IN-1 packets.

Protocol:
- The block adds no buffering. AXI-Stream permits comb paths, so m_tready->s_tready and s_*->m_* are combinational.
- Output stability when TVALID && !TREADY follows from the upstream's stability, because grant is frozen in BUSY.
- A non-granted port sees s_tready=0 and must hold its beat.
- TSTRB is not carried; downstream treats TSTRB=TKEEP.

Boundary cases:
- A single-beat packet (TLAST on the first beat) takes IDLE->BUSY->IDLE.
- A requester that drops TVALID in IDLE before the grant registers still receives the grant. The block then waits in BUSY for that port's packet.
- Round-robin wrap from NUM_IN-1 back to 0 must be exercised.

Decomposition:
- Package axi_stream_arb_pkg: state enum {IDLE, BUSY}, clog2 function, IDX_W helper.
- Sub-module axi_stream_rr_pick: purely combinational.
  - Inputs: req[NUM_IN], last[IDX_W].
  - Outputs: pick[IDX_W], any.
  - Implemented as a double-width rotate plus priority encoder.
- FSM, grant registers and output mux live in the top module.

Test Plan:
1. Reset then port 2 sends a 3-beat packet, m_tready=1:
   - Grant registered 1 cycle after s_tvalid[2].
   - m_tid=2 for 3 beats, m_tlast on beat 3.
   - busy falls the following cycle.
2. All 4 ports hold 2-beat packets continuously:
   - Output packet order is 0,1,2,3,0.
   - One IDLE cycle between packets.
   - No beats from different ports interleave.
3. Port 1 mid-packet while m_tready toggles 1,0,0,1:
   - m_tdata holds stable while m_tvalid && !m_tready.
   - s_tready[1] mirrors m_tready.
   - s_tready[0,2,3] stay 0 with their s_tvalid=1.
4. Port 3 holds the grant and drops s_tvalid for 2 cycles between beats while port 0 requests:
   - Grant stays on 3 until its TLAST beat is accepted.
   - Port 0 is granted next.
5. resetn pulsed low during beat 2 of a 4-beat packet from port 1:
   - m_tvalid and s_tready go to 0 asynchronously.
   - After release, ports 1 and 3 requesting gives port 1 the grant (last_grant reset to 3).
6. Port 0 sends a single-beat packet with TLAST and TKEEP=4'b0011:
   - Passed through unchanged.
   - IDLE->BUSY->IDLE in 2 cycles.
